// File: rtl/eer_rl_pkg.sv
// Shared types and constants for the packet transmit builder.
package eer_rl_pkg;

  localparam int unsigned WORD_WIDTH = 16;
  localparam logic [15:0] BCAST_ID   = 16'hFFFF;

  // Packet types; encoding 3 is reserved as invalid.
  typedef enum logic [1:0] {
    PKT_HB = 2'd0,
    PKT_MR = 2'd1,
    PKT_DP = 2'd2
  } pkt_type_t;

  localparam logic [1:0] PKT_INVALID = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } tx_state_t;

  localparam int unsigned IDX_W     = 4;
  localparam int unsigned MAX_WORDS = 9;

  localparam logic [IDX_W-1:0] HB_LEN = 4'd6;
  localparam logic [IDX_W-1:0] MR_LEN = 4'd8;
  localparam logic [IDX_W-1:0] DP_LEN = 4'd9;

  // Header word layout.
  localparam int unsigned HDR_TYPE_MSB = 15;
  localparam int unsigned HDR_TYPE_LSB = 14;
  localparam int unsigned HDR_LEN_MSB  = 7;
  localparam int unsigned HDR_LEN_LSB  = 0;

  // Packet length in words for a given type (0 for the invalid encoding).
  function automatic logic [IDX_W-1:0] pkt_len(input logic [1:0] t);
    logic [IDX_W-1:0] len;
    len = '0;
    case (pkt_type_t'(t))
      PKT_HB:  len = HB_LEN;
      PKT_MR:  len = MR_LEN;
      PKT_DP:  len = DP_LEN;
      default: len = '0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/pkt_tx_builder.sv
// Builds and streams one HB/MR/DP packet per start request over a
// valid/ready word interface.
// Ports:
//   clk, nrst            clock, synchronous active-high reset
//   start, pktType       packet request and type (3 = invalid -> err pulse)
//   my*, chosenCH, hopsFromCH, destID, payload   packet fields, captured on start
//   txReady              downstream accepts txData this cycle
//   txData/txValid/txLast  outgoing word stream
//   busy, done, err      status; done and err are one-cycle pulses
module pkt_tx_builder #(
  parameter int unsigned           WORD_WIDTH = eer_rl_pkg::WORD_WIDTH,
  parameter logic [WORD_WIDTH-1:0] BCAST_ID   = WORD_WIDTH'(eer_rl_pkg::BCAST_ID)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start,
  input  logic [1:0]            pktType,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] destID,
  input  logic [WORD_WIDTH-1:0] payload,
  input  logic                  txReady,
  output logic [WORD_WIDTH-1:0] txData,
  output logic                  txValid,
  output logic                  txLast,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  import eer_rl_pkg::*;

  tx_state_t             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W-1:0]      len_q, len_d;
  logic [WORD_WIDTH-1:0] words_q [MAX_WORDS];
  logic [WORD_WIDTH-1:0] words_d [MAX_WORDS];
  logic [WORD_WIDTH-1:0] hdr;
  logic [IDX_W-1:0]      new_len;

  logic [WORD_WIDTH-1:0] tx_data_d;
  logic                  tx_valid_d, tx_last_d, busy_d, done_d, err_d;

  // Header word for the request currently on the inputs.
  always_comb begin
    new_len = pkt_len(pktType);
    hdr     = '0;
    hdr[HDR_TYPE_MSB:HDR_TYPE_LSB] = pktType;
    hdr[HDR_LEN_MSB:HDR_LEN_LSB]   = 8'(new_len);
  end

  // Next-state, capture and registered-output decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    words_d = words_q;
    err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (pktType == PKT_INVALID) begin
            err_d = 1'b1;
          end else begin
            state_d    = ST_SEND;
            idx_d      = '0;
            len_d      = new_len;
            words_d[0] = hdr;
            words_d[1] = myNodeID;
            words_d[2] = (pkt_type_t'(pktType) == PKT_HB) ? BCAST_ID : destID;
            words_d[3] = myHops;
            words_d[4] = myQValue;
            words_d[5] = myEnergy;
            words_d[6] = hopsFromCH;
            words_d[7] = chosenCH;
            words_d[8] = payload;
          end
        end
      end
      ST_SEND: begin
        // txValid is always high in SEND, so txReady alone marks acceptance.
        if (txReady) begin
          if (idx_q == IDX_W'(len_q - 4'd1)) begin
            state_d = ST_DONE;
            idx_d   = '0;
          end else begin
            idx_d = IDX_W'(idx_q + 4'd1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase

    // Outputs derived from next state so they register in step with it.
    tx_valid_d = (state_d == ST_SEND);
    tx_data_d  = tx_valid_d ? words_d[idx_d] : '0;
    tx_last_d  = tx_valid_d && (idx_d == IDX_W'(len_d - 4'd1));
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
  end

  // State, captured packet and output registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      words_q <= '{default: '0};
      txData  <= '0;
      txValid <= 1'b0;
      txLast  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      words_q <= words_d;
      txData  <= tx_data_d;
      txValid <= tx_valid_d;
      txLast  <= tx_last_d;
      busy    <= busy_d;
      done    <= done_d;
      err     <= err_d;
    end
  end

endmodule

// File: tb/tb_pkt_tx_builder.sv
// Scoreboard bench for pkt_tx_builder: stimulus pushes expected words,
// a negedge monitor pops and compares every accepted word.
module tb_pkt_tx_builder;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         nrst, start, txReady;
  logic [1:0]   pktType;
  logic [W-1:0] myNodeID, myHops, myQValue, myEnergy;
  logic [W-1:0] chosenCH, hopsFromCH, destID, payload;
  logic [W-1:0] txData;
  logic         txValid, txLast, busy, done, err;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int cyc = 0;
  int ready_mode = 0;   // 0: always ready, 1: pattern 1,0,0, 2: never ready

  logic [W:0] exp_q [$];   // {last, data}

  pkt_tx_builder dut (
    .clk(clk), .nrst(nrst), .start(start), .pktType(pktType),
    .myNodeID(myNodeID), .myHops(myHops), .myQValue(myQValue), .myEnergy(myEnergy),
    .chosenCH(chosenCH), .hopsFromCH(hopsFromCH), .destID(destID), .payload(payload),
    .txReady(txReady), .txData(txData), .txValid(txValid), .txLast(txLast),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    case (ready_mode)
      0:       txReady = 1'b1;
      1:       txReady = (cyc % 3 == 0);
      default: txReady = 1'b0;
    endcase
  endtask

  task automatic set_inputs(input logic [1:0] t, input logic [W-1:0] id, input logic [W-1:0] hops,
                            input logic [W-1:0] q, input logic [W-1:0] en, input logic [W-1:0] hch,
                            input logic [W-1:0] ch, input logic [W-1:0] dst, input logic [W-1:0] pay);
    pktType = t; myNodeID = id; myHops = hops; myQValue = q; myEnergy = en;
    hopsFromCH = hch; chosenCH = ch; destID = dst; payload = pay;
  endtask

  // Reference packet model from the current inputs.
  task automatic push_pkt();
    logic [W-1:0] w [9];
    int len;
    len = (pktType == 2'd0) ? 6 : (pktType == 2'd1) ? 8 : 9;
    w[0] = {pktType, 6'b0, 8'(len)};
    w[1] = myNodeID;
    w[2] = (pktType == 2'd0) ? 16'hFFFF : destID;
    w[3] = myHops;
    w[4] = myQValue;
    w[5] = myEnergy;
    w[6] = hopsFromCH;
    w[7] = chosenCH;
    w[8] = payload;
    for (int i = 0; i < len; i++) exp_q.push_back({(i == len - 1), w[i]});
  endtask

  task automatic wait_done(input int k0, input int expk, input bit start_in_done);
    int k;
    k = k0;
    while (!done && k < 100) begin
      tick();
      k++;
    end
    chk("done_seen", 32'(done), 32'd1);
    if (expk > 0) chk("done_cycle", 32'(k), 32'(expk));
    chk("busy_in_done", 32'(busy), 32'd1);
    if (start_in_done) begin
      start = 1'b1;
      pktType = 2'd0;
    end
    tick();
    start = 1'b0;
    chk("done_pulse_end", 32'(done), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("valid_idle", 32'(txValid), 32'd0);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare accepted words, stall stability, idle data.
  logic         stalled = 1'b0;
  logic [W:0]   held;
  always @(negedge clk) begin
    if (nrst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && txValid) chk("stall_stable", 32'({txLast, txData}), 32'(held));
      if (txValid && txReady) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'({txLast, txData}), 32'hDEAD_0000);
        end else begin
          chk("tx_word", 32'({txLast, txData}), 32'(exp_q.pop_front()));
          accepted++;
        end
      end
      if (!txValid) chk("idle_data_zero", 32'({txLast, txData}), 32'd0);
      stalled = txValid && !txReady;
      held    = {txLast, txData};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc0;
    nrst = 1'b1; start = 1'b0; txReady = 1'b0;
    set_inputs(2'd0, '0, '0, '0, '0, '0, '0, '0, '0);
    tick(); tick();
    chk("rst_valid", 32'(txValid), 32'd0);
    chk("rst_last",  32'(txLast),  32'd0);
    chk("rst_data",  32'(txData),  32'd0);
    chk("rst_busy",  32'(busy),    32'd0);
    chk("rst_done",  32'(done),    32'd0);
    chk("rst_err",   32'(err),     32'd0);
    nrst = 1'b0;
    tick();

    // Heartbeat, always ready: done 7 cycles after start.
    set_inputs(2'd0, 16'h0005, 16'h0002, 16'h0011, 16'h0064, 16'h0007, 16'h0009, 16'h1234, 16'hAAAA);
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    chk("hb_w0_latency", 32'({txValid, txData}), 32'h1_0006);
    wait_done(1, 7, 0);

    // Data packet; a start landing in the DONE cycle is ignored.
    set_inputs(2'd2, 16'h0021, 16'h0001, 16'h0033, 16'h0050, 16'h0002, 16'h0004, 16'h0003, 16'hBEEF);
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    chk("dp_w0", 32'(txData), 32'h8009);
    wait_done(1, 10, 1);
    chk("start_in_done_ignored", 32'(txValid), 32'd0);

    // Membership request with stalls.
    ready_mode = 1;
    acc0 = accepted;
    set_inputs(2'd1, 16'h0042, 16'h0003, 16'h0077, 16'h0099, 16'h0001, 16'h0008, 16'h0044, 16'h5555);
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    wait_done(1, -1, 0);
    chk("mr_word_count", 32'(accepted - acc0), 32'd8);
    ready_mode = 0;
    tick();

    // Invalid type: err pulse only.
    pktType = 2'd3; start = 1'b1;
    tick(); start = 1'b0;
    chk("inv_err", 32'(err), 32'd1);
    chk("inv_valid", 32'(txValid), 32'd0);
    chk("inv_busy", 32'(busy), 32'd0);
    tick();
    chk("inv_err_end", 32'(err), 32'd0);
    chk("inv_busy2", 32'(busy), 32'd0);

    // Second start during SEND with changed inputs is ignored.
    set_inputs(2'd0, 16'h000A, 16'h0004, 16'h0020, 16'h0030, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    tick();
    set_inputs(2'd2, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD, 16'h0BAD);
    start = 1'b1;
    tick(); start = 1'b0;
    wait_done(3, 7, 0);
    for (int i = 0; i < 4; i++) tick();
    chk("no_second_pkt", 32'({busy, txValid}), 32'd0);

    // Reset after W3 is accepted abandons the packet.
    set_inputs(2'd0, 16'h0005, 16'h0002, 16'h0011, 16'h0064, 16'h0007, 16'h0009, 16'h1234, 16'hAAAA);
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    tick(); tick(); tick();
    ready_mode = 2;
    tick();
    nrst = 1'b1;
    tick();
    nrst = 1'b0;
    chk("rstmid_valid", 32'(txValid), 32'd0);
    chk("rstmid_last", 32'(txLast), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_remaining", 32'(exp_q.size()), 32'd2);
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rstmid_no_done", 32'({done, txValid}), 32'd0);
    end
    ready_mode = 0;
    tick();
    start = 1'b1; push_pkt();
    tick(); start = 1'b0;
    wait_done(1, 7, 0);

    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pkt_tx_builder.md
PKT_TX_BUILDER -- requirements
Module: pkt_tx_builder

Interface
REQ-001 Parameter WORD_WIDTH, default 16, width of every packet field and txData.
REQ-002 Parameter BCAST_ID, default 16'hFFFF, destination ID used for heartbeat packets.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 nrst  in  1  reset, synchronous and active-high: asserted when 1, sampled on clk.
REQ-005 start  in  1  one-cycle request to build and send one packet.
REQ-006 pktType  in  2  packet type: 0 = HB (heartbeat), 1 = MR (membership request), 2 = DP (data), 3 = invalid.
REQ-007 myNodeID, myHops, myQValue, myEnergy  in  WORD_WIDTH each  own-node information fields.
REQ-008 chosenCH, hopsFromCH  in  WORD_WIDTH each  current cluster-head selection.
REQ-009 destID, payload  in  WORD_WIDTH each  unicast destination and data word (DP only).
REQ-010 txReady  in  1  downstream radio accepts the word on txData this cycle.
REQ-011 txData  out  WORD_WIDTH  current packet word.
REQ-012 txValid  out  1  txData is valid.
REQ-013 txLast  out  1  current word is the final word of the packet.
REQ-014 busy  out  1  a packet is in progress.
REQ-015 done  out  1  one-cycle pulse after the final word is accepted.
REQ-016 err  out  1  one-cycle pulse when start arrives with pktType = 3.

Function
REQ-017 Packet words, in order: W0 header {pktType[15:14], 6'b0, length[7:0]}; W1 myNodeID; W2 dest; W3 myHops; W4 myQValue; W5 myEnergy; W6 hopsFromCH; W7 chosenCH; W8 payload.
REQ-018 Length is 6 for HB (W0-W5), 8 for MR (W0-W7) and 9 for DP (W0-W8).
REQ-019 dest is BCAST_ID for HB and destID for MR and DP.
REQ-020 All input fields are captured on the start cycle; input changes after that cycle do not affect the packet in flight.
REQ-021 FSM states are IDLE, SEND and DONE.
REQ-022 IDLE: on start with a valid pktType, capture fields and move to SEND; on start with pktType = 3, pulse err for one cycle and stay in IDLE.
REQ-023 SEND: hold txValid at 1; a word is accepted when txValid and txReady are both 1; each acceptance advances the word index.
REQ-024 SEND: on acceptance of word length-1, move to DONE.
REQ-025 DONE: done = 1 for exactly one cycle, then return to IDLE.
REQ-026 Latency: start in cycle N puts W0 on txData with txValid = 1 in cycle N+1.
REQ-027 With txReady held at 1, one word is accepted per cycle, and done is asserted in cycle N+1+length.
REQ-028 While txValid = 1 and txReady = 0, txData and txLast stay stable.
REQ-029 txLast = 1 only while the index is length-1 and txValid = 1.
REQ-030 busy = 1 in SEND and DONE; busy = 0 in IDLE.
REQ-031 start is ignored while busy = 1: no capture, no err, and the packet in flight is unaffected.
REQ-032 start in the same cycle that DONE returns to IDLE is ignored; a new start is honoured only from the first IDLE cycle.
REQ-033 When txValid = 0, txData = 0.
REQ-034 The word index is 4 bits wide and never exceeds 8.

Reset
REQ-035 When nrst = 1, on the next edge: state = IDLE, index = 0, captured fields = 0; txValid, txLast, busy, done and err = 0; txData = 0.
REQ-036 Reset during SEND abandons the packet: no further words, no txLast and no done.
REQ-037 Reset has priority over start in the same cycle.

Structure
REQ-038 Shared package eer_rl_pkg holds: pkt_type_t enum (HB, MR, DP), WORD_WIDTH, BCAST_ID, the length constants HB_LEN = 6, MR_LEN = 8, DP_LEN = 9, and the header bit positions.
REQ-039 The block is a single module with no sub-module; word selection is an index-driven multiplexer inside the module.

Verification
REQ-040 HB, myNodeID = 0x0005, txReady = 1: words 0x0006, 0x0005, 0xFFFF, hops, Q, energy; txLast on word 6; done in cycle N+7.
REQ-041 DP, destID = 0x0003, payload = 0xBEEF: W0 = 0x8009, W2 = 0x0003, W8 = 0xBEEF with txLast = 1.
REQ-042 MR with txReady toggling 1,0,0,1...: each word is held stable while stalled; all 8 words delivered exactly once in order.
REQ-043 start with pktType = 3: err pulses for 1 cycle; txValid stays 0; busy stays 0.
REQ-044 Second start during SEND with the inputs changed: the first packet is unchanged and no second packet is sent.
REQ-045 nrst = 1 after W3 is accepted: txValid = 0 on the next cycle; no done; a fresh HB afterwards is correct.
